// File: rtl/uart_rx_if.sv
// Receiver-side bundle: frame configuration in, decoded byte and status strobes out.
// The receiver takes the master modport; the system controller takes the slave side.
interface uart_rx_if #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
);
   logic [PRESCALE_WIDTH-1:0] prescale;
   logic                      parity_enable;
   logic                      parity_type;
   logic [DATA_WIDTH-1:0]     P_DATA;
   logic                      data_valid;
   logic                      parity_error;
   logic                      stop_error;
   logic                      busy;

   modport master (
      input  prescale, parity_enable, parity_type,
      output P_DATA, data_valid, parity_error, stop_error, busy
   );

   modport slave (
      output prescale, parity_enable, parity_type,
      input  P_DATA, data_valid, parity_error, stop_error, busy
   );
endinterface

// File: rtl/uart_rx.sv
// Oversampling UART receiver: 2-flop synchroniser, majority-vote bit recovery,
// optional even/odd parity, stop check, one-cycle result strobes.
//
// state  | meaning
// IDLE   | line idle; waits for a high-to-low transition on rx_s
// START  | validating start bit; a high mid-bit vote rejects it as a glitch
// DATA   | shifting in DATA_WIDTH data bits, LSB first
// PARITY | sampling parity bit and recording mismatch
// STOP   | sampling stop bit; result strobes launch at the decision point
// DONE   | completion cycle: strobes visible, busy still high
module uart_rx #(
   parameter int DATA_WIDTH     = 8,
   parameter int PRESCALE_WIDTH = 6
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        RX_IN,
   uart_rx_if.master   bus
);
   localparam int PW = PRESCALE_WIDTH;
   localparam int BW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;

   typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP, DONE} state_t;

   state_t                state;
   logic                  rx_meta;
   logic                  rx_s;
   logic                  armed;
   logic [PW-1:0]         edge_cnt;
   logic [BW-1:0]         bit_cnt;
   logic [PW-1:0]         presc_l;
   logic                  pe_l;
   logic                  pt_l;
   logic                  s0;
   logic                  s1;
   logic                  par_err;
   logic [DATA_WIDTH-1:0] shreg;

   logic [PW-1:0] half;
   logic          sample_lo;
   logic          sample_mid;
   logic          decide;
   logic          bit_end;
   logic          bit_val;

   always_comb begin
      half       = presc_l >> 1;
      sample_lo  = (edge_cnt == half - PW'(1));
      sample_mid = (edge_cnt == half);
      decide     = (edge_cnt == half + PW'(1));
      bit_end    = (edge_cnt == presc_l - PW'(1));
      bit_val    = (s0 & s1) | (s0 & rx_s) | (s1 & rx_s);
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         rx_meta <= 1'b1;
         rx_s    <= 1'b1;
      end else begin
         rx_meta <= RX_IN;
         rx_s    <= rx_meta;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         state            <= IDLE;
         armed            <= 1'b0;
         edge_cnt         <= '0;
         bit_cnt          <= '0;
         presc_l          <= PW'(8);
         pe_l             <= 1'b0;
         pt_l             <= 1'b0;
         s0               <= 1'b0;
         s1               <= 1'b0;
         par_err          <= 1'b0;
         shreg            <= '0;
         bus.P_DATA       <= '0;
         bus.data_valid   <= 1'b0;
         bus.parity_error <= 1'b0;
         bus.stop_error   <= 1'b0;
         bus.busy         <= 1'b0;
      end else begin
         bus.data_valid   <= 1'b0;
         bus.parity_error <= 1'b0;
         bus.stop_error   <= 1'b0;

         if (state != IDLE && state != DONE) begin
            edge_cnt <= bit_end ? '0 : edge_cnt + PW'(1);
            if (sample_lo)  s0 <= rx_s;
            if (sample_mid) s1 <= rx_s;
         end

         case (state)
            IDLE: begin
               // armed guarantees a true falling edge, so a line stuck low never retriggers
               if (armed && !rx_s) begin
                  state    <= START;
                  armed    <= 1'b0;
                  edge_cnt <= '0;
                  par_err  <= 1'b0;
                  bus.busy <= 1'b1;
                  pe_l     <= bus.parity_enable;
                  pt_l     <= bus.parity_type;
                  if (bus.prescale == PW'(16) || bus.prescale == PW'(32))
                     presc_l <= bus.prescale;
                  else
                     presc_l <= PW'(8);
               end else if (rx_s) begin
                  armed <= 1'b1;
               end
            end
            START: begin
               if (decide && bit_val) begin
                  state    <= IDLE;
                  armed    <= 1'b1;
                  bus.busy <= 1'b0;
               end else if (bit_end) begin
                  state   <= DATA;
                  bit_cnt <= '0;
               end
            end
            DATA: begin
               if (decide) shreg <= {bit_val, shreg[DATA_WIDTH-1:1]};
               if (bit_end) begin
                  if (bit_cnt == BW'(DATA_WIDTH - 1))
                     state <= pe_l ? PARITY : STOP;
                  else
                     bit_cnt <= bit_cnt + BW'(1);
               end
            end
            PARITY: begin
               if (decide) par_err <= bit_val ^ (^shreg) ^ pt_l;
               if (bit_end) state <= STOP;
            end
            STOP: begin
               if (decide) begin
                  state <= DONE;
                  armed <= bit_val;
                  if (!bit_val) begin
                     bus.stop_error   <= 1'b1;
                     bus.parity_error <= par_err;
                  end else if (par_err) begin
                     bus.parity_error <= 1'b1;
                  end else begin
                     bus.P_DATA     <= shreg;
                     bus.data_valid <= 1'b1;
                  end
               end
            end
            DONE: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
               if (rx_s) armed <= 1'b1;
            end
            default: begin
               state    <= IDLE;
               bus.busy <= 1'b0;
            end
         endcase
      end
   end
endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are modelled when driven, and each result
// strobe pops and compares one expected outcome.
module tb_uart_rx;
   localparam int DW = 8;
   localparam int PW = 6;

   logic clk   = 1'b0;
   logic rst   = 1'b0;
   logic rx_in = 1'b1;

   uart_rx_if #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) bus ();

   uart_rx #(.DATA_WIDTH(DW), .PRESCALE_WIDTH(PW)) dut (
      .clk   (clk),
      .rst   (rst),
      .RX_IN (rx_in),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic          dv;
      logic          pe;
      logic          se;
      logic [DW-1:0] data;
   } exp_t;

   exp_t          sb[$];
   exp_t          got;
   logic [DW-1:0] last_good = '0;
   int            n_checks  = 0;
   int            n_errors  = 0;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (rst && (bus.data_valid || bus.parity_error || bus.stop_error)) begin
         if (sb.size() == 0) begin
            check("unexpected_strobe",
                  {29'd0, bus.data_valid, bus.parity_error, bus.stop_error}, 32'd0);
         end else begin
            got = sb.pop_front();
            check("data_valid",   {31'd0, bus.data_valid},   {31'd0, got.dv});
            check("parity_error", {31'd0, bus.parity_error}, {31'd0, got.pe});
            check("stop_error",   {31'd0, bus.stop_error},   {31'd0, got.se});
            check("p_data",       {24'd0, bus.P_DATA},       {24'd0, got.data});
         end
      end
   end

   task automatic drive_bit(input logic v, input int p);
      rx_in = v;
      repeat (p) @(negedge clk);
   endtask

   task automatic idle(input int n);
      rx_in = 1'b1;
      repeat (n) @(negedge clk);
   endtask

   task automatic send_frame(input logic [DW-1:0] d, input int p, input logic pe,
                             input logic pt, input logic par_flip, input logic stop,
                             input logic flip_cfg);
      logic par;
      logic mism;
      exp_t e;
      bus.prescale      = PW'(p);
      bus.parity_enable = pe;
      bus.parity_type   = pt;
      par  = (^d) ^ pt ^ par_flip;
      mism = pe && (par != ((^d) ^ pt));
      e    = '0;
      if (!stop) begin
         e.se   = 1'b1;
         e.pe   = mism;
         e.data = last_good;
      end else if (mism) begin
         e.pe   = 1'b1;
         e.data = last_good;
      end else begin
         e.dv      = 1'b1;
         e.data    = d;
         last_good = d;
      end
      sb.push_back(e);
      drive_bit(1'b0, p);
      for (int i = 0; i < DW; i++) begin
         if (flip_cfg && i == 2) begin
            bus.prescale      = PW'(16);
            bus.parity_enable = 1'b1;
         end
         drive_bit(d[i], p);
      end
      if (pe) drive_bit(par, p);
      drive_bit(stop, p);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() != 0 && n < 400) begin
         @(negedge clk);
         n++;
      end
      check("sb_drain", sb.size(), 32'd0);
   endtask

   initial begin
      int busy_cnt;
      bus.prescale      = PW'(8);
      bus.parity_enable = 1'b0;
      bus.parity_type   = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_p_data",       {24'd0, bus.P_DATA},       32'd0);
      check("rst_data_valid",   {31'd0, bus.data_valid},   32'd0);
      check("rst_parity_error", {31'd0, bus.parity_error}, 32'd0);
      check("rst_stop_error",   {31'd0, bus.stop_error},   32'd0);
      check("rst_busy",         {31'd0, bus.busy},         32'd0);
      rst = 1'b1;
      idle(16);

      // prescale 8, no parity
      send_frame(8'hA5, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(10);
      drain();

      // prescale 16, even parity: good then corrupted parity bit
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(20);
      send_frame(8'h3C, 16, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0);
      idle(20);
      drain();

      // prescale 32, odd parity, stop bit low; line then held low
      send_frame(8'h00, 32, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
      rx_in = 1'b0;
      repeat (96) @(negedge clk);
      check("stuck_low_busy", {31'd0, bus.busy}, 32'd0);
      idle(40);
      drain();

      // short glitch at prescale 8
      bus.prescale      = PW'(8);
      bus.parity_enable = 1'b0;
      rx_in = 1'b0;
      repeat (2) @(negedge clk);
      rx_in    = 1'b1;
      busy_cnt = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (bus.busy) busy_cnt++;
      end
      check("glitch_busy_seen", {31'd0, busy_cnt > 0}, 32'd1);
      check("glitch_busy_lt_p", {31'd0, busy_cnt < 8}, 32'd1);
      check("glitch_idle",      {31'd0, bus.busy},     32'd0);

      // back-to-back frames, then a frame with config changed mid-frame
      send_frame(8'h55, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'hAA, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      send_frame(8'h66, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1);
      idle(10);
      drain();

      // reset during data bit 4
      bus.prescale      = PW'(8);
      bus.parity_enable = 1'b0;
      drive_bit(1'b0, 8);
      for (int i = 0; i < 4; i++) drive_bit(1'b1, 8);
      drive_bit(1'b0, 4);
      rst = 1'b0;
      #1;
      check("abort_p_data",     {24'd0, bus.P_DATA},     32'd0);
      check("abort_busy",       {31'd0, bus.busy},       32'd0);
      check("abort_data_valid", {31'd0, bus.data_valid}, 32'd0);
      last_good = '0;
      @(negedge clk);
      rx_in = 1'b1;
      repeat (3) @(negedge clk);
      rst = 1'b1;
      idle(16);
      send_frame(8'h81, 8, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
      idle(10);
      drain();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end
endmodule

// File: doc/uart_rx.md
Name: uart_rx

Overview:
- Asynchronous serial receiver; the receive-side counterpart of the UART transmit path in the UART block.
- Oversamples the serial line, detects start bit, recovers LSB-first data with optional even/odd parity, checks stop bit.
- Presents the received byte with a one-cycle valid strobe plus error flags to the system controller / RX clock-domain logic.

Parameters:
DATA_WIDTH, 8, number of data bits per frame
PRESCALE_WIDTH, 6, width of prescale input

Ports:
clk  input  1  receive oversampling clock
rst  input  1  asynchronous active-low reset
RX_IN  input  1  serial line, idle high, asynchronous to clk
prescale  input  PRESCALE_WIDTH  oversampling ratio per bit; legal 8, 16, 32
parity_enable  input  1  1 = parity bit present in frame
parity_type  input  1  0 = even, 1 = odd
P_DATA  output  DATA_WIDTH  last received data byte
data_valid  output  1  one-cycle strobe: P_DATA holds a good frame
parity_error  output  1  one-cycle strobe: parity mismatch on completed frame
stop_error  output  1  one-cycle strobe: stop bit sampled low
busy  output  1  high while a frame is being received

Behaviour:
- Reset (rst low, async): FSM to IDLE; P_DATA=0, data_valid=0, parity_error=0, stop_error=0, busy=0; synchroniser flops set to 1; counters cleared.
- RX_IN passes through a 2-flop synchroniser (rx_s); all decisions use rx_s. Latency RX_IN -> rx_s = 2 clk.
- Config latch: prescale, parity_enable, parity_type captured on the IDLE->START transition; changes mid-frame are ignored. Any prescale value other than 8/16/32 is treated as 8.
- Counters: edge_cnt counts 0..P-1 within each bit (P = latched prescale); bit_cnt indexes data bits 0..DATA_WIDTH-1.
- Sampling: rx_s captured at edge_cnt = P/2-1, P/2, P/2+1; bit value = majority of the three; bit decided at edge_cnt = P/2+1.
- States:
  - IDLE: busy=0. When rx_s==0, go to START with edge_cnt=0 in that cycle.
  - START: at decision point, if bit==1 (glitch), go to IDLE with no flags. Otherwise continue to edge_cnt=P-1, then go to DATA with bit_cnt=0.
  - DATA: each decided bit shifts into a shift register, LSB first. After bit DATA_WIDTH-1 completes (edge_cnt=P-1), go to PARITY if parity enabled, else STOP.
  - PARITY: decided bit compared to the XOR of the data bits, inverted for odd parity; the mismatch is held internally. At edge_cnt=P-1 go to STOP.
  - STOP: at decision point, evaluate stop bit and finish the frame in the next cycle, then go to IDLE. No wait for the remaining half bit, so back-to-back frames resynchronise on the next start edge.
- Frame completion (cycle after STOP decision), priority rules:
  - stop bit 1 and no parity mismatch: P_DATA <= shift register; data_valid=1 for exactly one cycle.
  - stop bit 0: stop_error=1 for one cycle; parity_error asserts in the same cycle if a parity mismatch is also present.
  - parity mismatch only: parity_error=1 for one cycle.
  - Whenever any error is flagged: data_valid stays 0 and P_DATA holds its previous value.
- busy=1 from the START entry cycle through the completion cycle, inclusive.
- Line held low after a stop error: the next frame starts only once rx_s returns high and then falls again. FSM requires rx_s==1 in IDLE before a falling detect; it does not retrigger on a steady low.
- Reset asserted mid-frame aborts immediately. No flags are generated.

Test Plan:
- prescale=8, parity off, send 0xA5 (start, 1,0,1,0,0,1,0,1, stop) -> data_valid pulses once, 1 cycle after stop-bit decision; P_DATA=0xA5; no error flags.
- prescale=16, parity_enable=1, parity_type=0, send 0x3C with parity bit 0 -> P_DATA=0x3C, data_valid=1. Repeat with parity bit 1 -> parity_error=1, data_valid=0, P_DATA stays 0x3C.
- prescale=32, odd parity, 0x00 with parity 1 but stop bit 0 -> stop_error=1, data_valid=0.
- RX_IN low pulse of 2 clk at prescale=8 -> START rejects glitch, return to IDLE; no flags; busy high for <P cycles only.
- Two back-to-back frames 0x55 then 0xAA at prescale=8, no idle gap -> two data_valid pulses with correct bytes. Also flip prescale mid-frame -> current frame decodes using the latched value.
- Assert rst during DATA bit 4 -> all outputs 0 immediately. A subsequent full frame 0x81 is received correctly.
